reg_wb_queue: RTL and testbench
===============================

// Module: reg_wb_queue
// PURPOSE
//  Write-side companion to the dual-issue register file. Accepts up to two
//   retiring results per cycle (lane0 = older/pipeline 1, lane1 = younger/pipeline 2).
//  Buffers them in a pair FIFO and drains one pair per cycle onto write ports 3/6.
//  Forwards in-flight values to the four read-address queries, so decode never reads stale data.
// PARAMETERS
//  ADDRESS_WIDTH  5   register index width (32 regs)
//  DATA_WIDTH     32  register data width
//  DEPTH          4   FIFO depth in pair-entries; power of 2, >=2
// PORTS
//  clk        in   1      clock; all state updates on posedge
//  rst        in   1      synchronous active-high reset
//  in_valid0  in   1      lane0 result valid
//  in_rd0     in   AW     lane0 destination register
//  in_data0   in   DW     lane0 result
//  in_valid1  in   1      lane1 result valid
//  in_rd1     in   AW     lane1 destination register
//  in_data1   in   DW     lane1 result
//  in_ready   out  1      queue accepts a pair this cycle (= count<DEPTH)
//  drain_en   in   1      allow pop of head pair this cycle
//  AD3/WD3/WE3 out AW/DW/1 write port 3 (lane0), registered
//  AD6/WD6/WE6 out AW/DW/1 write port 6 (lane1), registered
//  fwd_addr1/2/4/5 in AW  read-address queries (rs1,rs2,rs4,rs5)
//  fwd_hit1/2/4/5  out 1  query matches an in-flight write
//  fwd_data1/2/4/5 out DW newest in-flight value for that query
//  count      out  $clog2(DEPTH)+1  occupied entries
// BEHAVIOUR
//  Reset: head=tail=count=0; WE3=WE6=0, AD3=AD6=0, WD3=WD6=0; all fwd_hit=0.
//  Filter at enqueue: lane with rd==0 is invalid.
//   If both lanes are valid with equal rd, lane0 is dropped (younger wins).
//  Invariant: WE3&&WE6 implies AD3!=AD6. The register file drops port 6 on an address clash.
//  Enqueue at posedge when in_ready && (filtered v0||v1). A pair with both lanes filtered is discarded:
//   no entry, count unchanged. Enqueue is ignored when in_ready=0 (producer holds).
//  Pop at posedge when drain_en && count>0 (count sampled before edge).
//   A pair enqueued into an empty queue pops no earlier than the next edge.
//  Output stage: the edge that pops loads WEn/ADn/WDn from the head lanes.
//   Any other edge forces WE3=WE6=0; AD/WD hold their last values.
//  Latency: in_valid edge N -> WE pulse in cycle after edge N+1 (min 2 cycles), one cycle wide.
//  Ordering: strict FIFO; lane0 always to port 3, lane1 always to port 6.
//  Simultaneous enqueue+pop: count unchanged. Pointers wrap modulo DEPTH.
//  Full: count==DEPTH -> in_ready=0, even if a pop occurs this cycle.
//  Forwarding (combinational), search newest to oldest: entries tail-1..head, then output stage (if WEn).
//   Within an entry, lane1 wins over lane0. Address 0 never hits.
//  Reset mid-operation: all pending entries discarded; no WE asserted in the cycle after reset.
// TESTING
//  1 rst; lane0 x5=0xDEADBEEF, drain_en=1 -> 2 cycles later WE3=1 AD3=5 WD3=DEADBEEF for 1 cycle; WE6=0
//  2 both lanes rd=7, data 0x11/0x22 -> single entry; WE3=0, WE6=1 AD6=7 WD6=0x22; fwd_addr1=7 gives 0x22 while pending
//  3 lane0 rd=0, lane1 invalid -> no enqueue, count stays 0, no WE pulse
//  4 drain_en=0, enqueue 4 pairs (x3=1,x3=2 in entries 0 and 2) -> count=4, in_ready=0;
//    fwd_addr2=3 gives data 2; 5th pair held; drain_en=1 -> 4 consecutive in-order writes, pointer wraps
//  5 3 entries pending, assert rst 1 cycle -> count=0, WE3=WE6=0 next cycle, fwd_hit all 0
//  6 count=2, enqueue+pop same edge -> count=2, popped pair emitted, new pair at tail

Source files
------------

// File: rtl/reg_wb_queue.sv
// Write-back pair queue for the dual-issue register file. Retiring results are buffered
// as lane pairs, drained one pair per cycle onto write ports 3/6, and forwarded to decode.
module reg_wb_queue #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid0,
    input  logic [ADDRESS_WIDTH-1:0]      in_rd0,
    input  logic [DATA_WIDTH-1:0]         in_data0,
    input  logic                          in_valid1,
    input  logic [ADDRESS_WIDTH-1:0]      in_rd1,
    input  logic [DATA_WIDTH-1:0]         in_data1,
    output logic                          in_ready,
    input  logic                          drain_en,
    output logic [ADDRESS_WIDTH-1:0]      AD3,
    output logic [DATA_WIDTH-1:0]         WD3,
    output logic                          WE3,
    output logic [ADDRESS_WIDTH-1:0]      AD6,
    output logic [DATA_WIDTH-1:0]         WD6,
    output logic                          WE6,
    input  logic [ADDRESS_WIDTH-1:0]      fwd_addr1,
    input  logic [ADDRESS_WIDTH-1:0]      fwd_addr2,
    input  logic [ADDRESS_WIDTH-1:0]      fwd_addr4,
    input  logic [ADDRESS_WIDTH-1:0]      fwd_addr5,
    output logic                          fwd_hit1,
    output logic                          fwd_hit2,
    output logic                          fwd_hit4,
    output logic                          fwd_hit5,
    output logic [DATA_WIDTH-1:0]         fwd_data1,
    output logic [DATA_WIDTH-1:0]         fwd_data2,
    output logic [DATA_WIDTH-1:0]         fwd_data4,
    output logic [DATA_WIDTH-1:0]         fwd_data5,
    output logic [$clog2(DEPTH):0]        count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic                     r_v0  [DEPTH];
    logic [ADDRESS_WIDTH-1:0] r_rd0 [DEPTH];
    logic [DATA_WIDTH-1:0]    r_d0  [DEPTH];
    logic                     r_v1  [DEPTH];
    logic [ADDRESS_WIDTH-1:0] r_rd1 [DEPTH];
    logic [DATA_WIDTH-1:0]    r_d1  [DEPTH];
    logic [PW-1:0]            r_head;
    logic [PW-1:0]            r_tail;
    logic [CW-1:0]            r_count;
    logic                     r_we3;
    logic                     r_we6;
    logic [ADDRESS_WIDTH-1:0] r_ad3;
    logic [ADDRESS_WIDTH-1:0] r_ad6;
    logic [DATA_WIDTH-1:0]    r_wd3;
    logic [DATA_WIDTH-1:0]    r_wd6;

    logic w_v0;
    logic w_v1;
    logic w_push;
    logic w_pop;
    logic [DATA_WIDTH:0] w_f1;
    logic [DATA_WIDTH:0] w_f2;
    logic [DATA_WIDTH:0] w_f4;
    logic [DATA_WIDTH:0] w_f5;

    // Newest-wins lookup: scanning oldest to newest and overwriting leaves the newest match.
    function automatic logic [DATA_WIDTH:0] fwd_lookup(input logic [ADDRESS_WIDTH-1:0] addr);
        logic                  hit;
        logic [DATA_WIDTH-1:0] data;
        logic [PW-1:0]         idx;
        logic                  m;
        hit  = 1'b0;
        data = {DATA_WIDTH{1'b0}};
        m    = r_we3 && (r_ad3 == addr);
        hit  = m ? 1'b1 : hit;
        data = m ? r_wd3 : data;
        m    = r_we6 && (r_ad6 == addr);
        hit  = m ? 1'b1 : hit;
        data = m ? r_wd6 : data;
        for (int i = 0; i < DEPTH; i++) begin
            idx  = r_head + PW'(i);
            m    = (i < int'(r_count)) && r_v0[idx] && (r_rd0[idx] == addr);
            hit  = m ? 1'b1 : hit;
            data = m ? r_d0[idx] : data;
            m    = (i < int'(r_count)) && r_v1[idx] && (r_rd1[idx] == addr);
            hit  = m ? 1'b1 : hit;
            data = m ? r_d1[idx] : data;
        end
        hit = (addr == {ADDRESS_WIDTH{1'b0}}) ? 1'b0 : hit;
        return {hit, data};
    endfunction

    // Lane filter: x0 never written, and a same-address pair keeps only the younger lane.
    always_comb begin
        w_v1   = in_valid1 && (in_rd1 != {ADDRESS_WIDTH{1'b0}});
        w_v0   = in_valid0 && (in_rd0 != {ADDRESS_WIDTH{1'b0}}) && !(w_v1 && (in_rd1 == in_rd0));
        w_push = in_ready && (w_v0 || w_v1);
        w_pop  = drain_en && (r_count != {CW{1'b0}});
    end

    assign in_ready = (r_count < CW'(DEPTH));
    assign count    = r_count;

    // Pair storage; valids are cleared on reset so stale entries can never forward.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_v0[i] <= 1'b0;
                r_v1[i] <= 1'b0;
            end
        end else if (w_push) begin
            r_v0[r_tail]  <= w_v0;
            r_rd0[r_tail] <= in_rd0;
            r_d0[r_tail]  <= in_data0;
            r_v1[r_tail]  <= w_v1;
            r_rd1[r_tail] <= in_rd1;
            r_d1[r_tail]  <= in_data1;
        end else begin
            r_v0[r_tail] <= r_v0[r_tail];
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= {PW{1'b0}};
            r_tail  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            r_head <= w_pop  ? r_head + {{(PW-1){1'b0}}, 1'b1} : r_head;
            r_tail <= w_push ? r_tail + {{(PW-1){1'b0}}, 1'b1} : r_tail;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{(CW-1){1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
        end
    end

    // Output stage: a pop loads both ports from the head pair; otherwise enables drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we3 <= 1'b0;
            r_we6 <= 1'b0;
            r_ad3 <= {ADDRESS_WIDTH{1'b0}};
            r_ad6 <= {ADDRESS_WIDTH{1'b0}};
            r_wd3 <= {DATA_WIDTH{1'b0}};
            r_wd6 <= {DATA_WIDTH{1'b0}};
        end else if (w_pop) begin
            r_we3 <= r_v0[r_head];
            r_we6 <= r_v1[r_head];
            r_ad3 <= r_rd0[r_head];
            r_ad6 <= r_rd1[r_head];
            r_wd3 <= r_d0[r_head];
            r_wd6 <= r_d1[r_head];
        end else begin
            r_we3 <= 1'b0;
            r_we6 <= 1'b0;
        end
    end

    assign WE3 = r_we3;
    assign WE6 = r_we6;
    assign AD3 = r_ad3;
    assign AD6 = r_ad6;
    assign WD3 = r_wd3;
    assign WD6 = r_wd6;

    // Four independent forwarding queries.
    always_comb begin
        w_f1 = fwd_lookup(fwd_addr1);
        w_f2 = fwd_lookup(fwd_addr2);
        w_f4 = fwd_lookup(fwd_addr4);
        w_f5 = fwd_lookup(fwd_addr5);
    end

    assign fwd_hit1  = w_f1[DATA_WIDTH];
    assign fwd_hit2  = w_f2[DATA_WIDTH];
    assign fwd_hit4  = w_f4[DATA_WIDTH];
    assign fwd_hit5  = w_f5[DATA_WIDTH];
    assign fwd_data1 = w_f1[DATA_WIDTH-1:0];
    assign fwd_data2 = w_f2[DATA_WIDTH-1:0];
    assign fwd_data4 = w_f4[DATA_WIDTH-1:0];
    assign fwd_data5 = w_f5[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_reg_wb_queue.sv
// Table-driven bench for reg_wb_queue: one vector per clock, expected values hand-computed.
module tb_reg_wb_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid0, in_valid1, drain_en, in_ready;
    logic [4:0]  in_rd0, in_rd1, AD3, AD6;
    logic [31:0] in_data0, in_data1, WD3, WD6;
    logic        WE3, WE6;
    logic [4:0]  fwd_addr1, fwd_addr2, fwd_addr4, fwd_addr5;
    logic        fwd_hit1, fwd_hit2, fwd_hit4, fwd_hit5;
    logic [31:0] fwd_data1, fwd_data2, fwd_data4, fwd_data5;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic v0; logic [4:0] rd0; logic [31:0] d0;
        logic v1; logic [4:0] rd1; logic [31:0] d1;
        logic dr; logic [4:0] q;
        logic we3; logic [4:0] ad3; logic [31:0] wd3;
        logic we6; logic [4:0] ad6; logic [31:0] wd6;
        logic [2:0] cnt; logic rdy; logic hit; logic [31:0] fd;
    } vec_t;

    vec_t tbl [22];

    reg_wb_queue #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid0(in_valid0), .in_rd0(in_rd0), .in_data0(in_data0),
        .in_valid1(in_valid1), .in_rd1(in_rd1), .in_data1(in_data1),
        .in_ready(in_ready), .drain_en(drain_en),
        .AD3(AD3), .WD3(WD3), .WE3(WE3), .AD6(AD6), .WD6(WD6), .WE6(WE6),
        .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2), .fwd_addr4(fwd_addr4), .fwd_addr5(fwd_addr5),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_hit4(fwd_hit4), .fwd_hit5(fwd_hit5),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .fwd_data4(fwd_data4), .fwd_data5(fwd_data5),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        in_valid0 = v.v0; in_rd0 = v.rd0; in_data0 = v.d0;
        in_valid1 = v.v1; in_rd1 = v.rd1; in_data1 = v.d1;
        drain_en  = v.dr;
        fwd_addr1 = v.q; fwd_addr2 = v.q; fwd_addr4 = v.q; fwd_addr5 = v.q;
    endtask

    task automatic check_vec(input string t, input vec_t v);
        chk({t, " count"}, 32'(count), 32'(v.cnt));
        chk({t, " in_ready"}, 32'(in_ready), 32'(v.rdy));
        chk({t, " WE3"}, 32'(WE3), 32'(v.we3));
        chk({t, " WE6"}, 32'(WE6), 32'(v.we6));
        if (v.we3) begin
            chk({t, " AD3"}, 32'(AD3), 32'(v.ad3));
            chk({t, " WD3"}, WD3, v.wd3);
        end
        if (v.we6) begin
            chk({t, " AD6"}, 32'(AD6), 32'(v.ad6));
            chk({t, " WD6"}, WD6, v.wd6);
        end
        chk({t, " hit1"}, 32'(fwd_hit1), 32'(v.hit));
        chk({t, " hit2"}, 32'(fwd_hit2), 32'(v.hit));
        chk({t, " hit4"}, 32'(fwd_hit4), 32'(v.hit));
        chk({t, " hit5"}, 32'(fwd_hit5), 32'(v.hit));
        if (v.hit) begin
            chk({t, " data1"}, fwd_data1, v.fd);
            chk({t, " data2"}, fwd_data2, v.fd);
            chk({t, " data4"}, fwd_data4, v.fd);
            chk({t, " data5"}, fwd_data5, v.fd);
        end
    endtask

    initial begin
        // v0 rd0 d0 | v1 rd1 d1 | drain q || we3 ad3 wd3 | we6 ad6 wd6 | cnt rdy hit fd
        tbl[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,   1'b1, 5'd5,  1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0,   3'd1, 1'b1, 1'b1, 32'hDEADBEEF};
        tbl[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,   1'b1, 5'd5,  1'b1, 5'd5, 32'hDEADBEEF,  1'b0, 5'd0,  32'h0,   3'd0, 1'b1, 1'b1, 32'hDEADBEEF};
        tbl[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,   1'b1, 5'd5,  1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0,   3'd0, 1'b1, 1'b0, 32'h0};
        tbl[3]  = '{1'b1, 5'd7,  32'h11,       1'b1, 5'd7,  32'h22,  1'b1, 5'd7,  1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0,   3'd1, 1'b1, 1'b1, 32'h22};
        tbl[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,   1'b1, 5'd7,  1'b0, 5'd0, 32'h0,         1'b1, 5'd7,  32'h22,  3'd0, 1'b1, 1'b1, 32'h22};
        tbl[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,   1'b1, 5'd7,  1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0,   3'd0, 1'b1, 1'b0, 32'h0};
        tbl[6]  = '{1'b1, 5'd0,  32'h33,       1'b0, 5'd0,  32'h0,   1'b1, 5'd0,  1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0,   3'd0, 1'b1, 1'b0, 32'h0};
        tbl[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,   1'b1, 5'd0,  1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0,   3'd0, 1'b1, 1'b0, 32'h0};
        tbl[8]  = '{1'b1, 5'd3,  32'h1,        1'b0, 5'd0,  32'h0,   1'b0, 5'd3,  1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0,   3'd1, 1'b1, 1'b1, 32'h1};
        tbl[9]  = '{1'b1, 5'd9,  32'hA9,       1'b1, 5'd10, 32'hAA,  1'b0, 5'd10, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0,   3'd2, 1'b1, 1'b1, 32'hAA};
        tbl[10] = '{1'b1, 5'd3,  32'h2,        1'b0, 5'd0,  32'h0,   1'b0, 5'd3,  1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0,   3'd3, 1'b1, 1'b1, 32'h2};
        tbl[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd11, 32'hBB,  1'b0, 5'd3,  1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0,   3'd4, 1'b0, 1'b1, 32'h2};
        tbl[12] = '{1'b1, 5'd12, 32'hCC,       1'b0, 5'd0,  32'h0,   1'b0, 5'd12, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0,   3'd4, 1'b0, 1'b0, 32'h0};
        tbl[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,   1'b1, 5'd3,  1'b1, 5'd3, 32'h1,         1'b0, 5'd0,  32'h0,   3'd3, 1'b1, 1'b1, 32'h2};
        tbl[14] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,   1'b1, 5'd10, 1'b1, 5'd9, 32'hA9,        1'b1, 5'd10, 32'hAA,  3'd2, 1'b1, 1'b1, 32'hAA};
        tbl[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,   1'b1, 5'd3,  1'b1, 5'd3, 32'h2,         1'b0, 5'd0,  32'h0,   3'd1, 1'b1, 1'b1, 32'h2};
        tbl[16] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,   1'b1, 5'd3,  1'b0, 5'd0, 32'h0,         1'b1, 5'd11, 32'hBB,  3'd0, 1'b1, 1'b0, 32'h0};
        tbl[17] = '{1'b1, 5'd1,  32'h101,      1'b0, 5'd0,  32'h0,   1'b0, 5'd1,  1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0,   3'd1, 1'b1, 1'b1, 32'h101};
        tbl[18] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd2,  32'h202, 1'b0, 5'd2,  1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0,   3'd2, 1'b1, 1'b1, 32'h202};
        tbl[19] = '{1'b1, 5'd4,  32'h404,      1'b1, 5'd5,  32'h505, 1'b1, 5'd5,  1'b1, 5'd1, 32'h101,       1'b0, 5'd0,  32'h0,   3'd2, 1'b1, 1'b1, 32'h505};
        tbl[20] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,   1'b1, 5'd1,  1'b0, 5'd0, 32'h0,         1'b1, 5'd2,  32'h202, 3'd1, 1'b1, 1'b0, 32'h0};
        tbl[21] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,   1'b1, 5'd4,  1'b1, 5'd4, 32'h404,       1'b1, 5'd5,  32'h505, 3'd0, 1'b1, 1'b1, 32'h404};

        // Power-on reset and reset-state checks.
        rst = 1'b1;
        drive('{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 3'd0, 1'b1, 1'b0, 32'h0});
        repeat (2) @(posedge clk);
        #1;
        chk("rst count", 32'(count), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst WE3", 32'(WE3), 32'd0);
        chk("rst WE6", 32'(WE6), 32'd0);
        chk("rst AD3", 32'(AD3), 32'd0);
        chk("rst AD6", 32'(AD6), 32'd0);
        chk("rst WD3", WD3, 32'd0);
        chk("rst WD6", WD6, 32'd0);
        chk("rst hit1", 32'(fwd_hit1), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            drive(tbl[i]);
            @(posedge clk);
            #1;
            check_vec($sformatf("vec%0d", i), tbl[i]);
        end

        // Reset mid-operation: three pending entries, reset asserted alongside a new enqueue.
        for (int i = 1; i <= 3; i++) begin
            drive('{1'b1, 5'(i), 32'(i * 16), 1'b0, 5'd0, 32'h0, 1'b0, 5'd1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 3'd0, 1'b1, 1'b0, 32'h0});
            @(posedge clk);
            #1;
        end
        chk("pre-rst count", 32'(count), 32'd3);
        chk("pre-rst hit2", 32'(fwd_hit2), 32'd1);
        chk("pre-rst data2", fwd_data2, 32'h10);
        rst = 1'b1;
        in_rd0 = 5'd6; drain_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid-rst count", 32'(count), 32'd0);
        chk("mid-rst in_ready", 32'(in_ready), 32'd1);
        chk("mid-rst WE3", 32'(WE3), 32'd0);
        chk("mid-rst WE6", 32'(WE6), 32'd0);
        chk("mid-rst hit1", 32'(fwd_hit1), 32'd0);
        fwd_addr2 = 5'd6;
        chk("mid-rst hit2", 32'(fwd_hit2), 32'd0);
        in_valid0 = 1'b0;
        @(posedge clk);
        #1;
        chk("post-rst WE3", 32'(WE3), 32'd0);
        chk("post-rst WE6", 32'(WE6), 32'd0);
        chk("post-rst count", 32'(count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
